inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 The parameter FIFO_DEPTH SHALL default to 4 and set the number of prefetched instruction words held.
REQ-002 The parameter MAX_OUTST SHALL default to 2 and set the maximum number of memory requests in flight.
REQ-003 The parameter RESET_PC SHALL default to 17'h00000 and set the first fetch address after reset.
REQ-004 The port clk SHALL be an input, 1 bit wide, and be the single clock; all state updates on its rising edge.
REQ-005 The port reset SHALL be an input, 1 bit wide, asynchronous and active-low.
REQ-006 The port mem_req SHALL be an output, 1 bit wide, and request a program-memory read.
REQ-007 The port mem_addr SHALL be an output, 17 bits wide, and carry the read address, valid while mem_req is high.
REQ-008 The port mem_gnt SHALL be an input, 1 bit wide; mem_req and mem_gnt high in the same cycle accept the request.
REQ-009 The port mem_rvalid SHALL be an input, 1 bit wide, and mark a read response; responses return in request order, at least 1 cycle after the grant.
REQ-010 The port mem_rdata SHALL be an input, 8 bits wide, and carry the response instruction word.
REQ-011 The port redirect SHALL be an input, 1 bit wide, and request a jump/branch restart.
REQ-012 The port redirect_pc SHALL be an input, 17 bits wide, and give the restart address.
REQ-013 The port inst_valid SHALL be an output, 1 bit wide, and be high when inst_reg holds a valid word.
REQ-014 The port inst_ready SHALL be an input, 1 bit wide; decode accepts the word when inst_valid and inst_ready are both high.
REQ-015 The port inst_reg SHALL be an output, 8 bits wide, and drive the instruction word to decode.
REQ-016 The port inst_pc SHALL be an output, 17 bits wide, and give the address of inst_reg.

Function
REQ-017 The FSM SHALL have three states: FETCH (issue requests), STALL (FIFO count + outstanding = FIFO_DEPTH, or outstanding = MAX_OUTST) and DRAIN (discard stale responses after a redirect).
REQ-018 In FETCH, mem_req SHALL be high with mem_addr = fetch_pc, and each grant SHALL increment fetch_pc by 1, wrapping 17'h1FFFF to 17'h00000.
REQ-019 The FSM SHALL go FETCH->STALL when a grant fills the credit limit, and STALL->FETCH in the cycle after a pop or response frees a credit.
REQ-020 mem_req SHALL stay high and mem_addr stable until granted, except when a redirect is applied.
REQ-021 Each mem_rvalid outside DRAIN SHALL push {mem_rdata, address} into the FIFO in that cycle.
REQ-022 inst_valid SHALL equal FIFO not-empty, with inst_reg and inst_pc taken from the FIFO head; latency from grant to inst_valid is the response latency plus 1 cycle.
REQ-023 inst_reg and inst_pc SHALL hold stable while inst_valid is high and inst_ready is low.
REQ-024 A push into an empty FIFO and a pop in the same cycle SHALL never occur; a push and a pop on a non-empty FIFO in the same cycle SHALL keep the count unchanged.
REQ-025 On redirect, a pop in the same cycle SHALL complete, then the FIFO SHALL be cleared, fetch_pc loaded with redirect_pc, and any request not yet granted withdrawn.
REQ-026 On redirect with zero outstanding, the FSM SHALL go to FETCH; otherwise it SHALL go to DRAIN with drop_cnt = outstanding (counting a grant in the same cycle).
REQ-027 In DRAIN, mem_req SHALL be low, responses SHALL be discarded with drop_cnt decremented, and the FSM SHALL go to FETCH when drop_cnt reaches 0.
REQ-028 A redirect arriving during DRAIN SHALL reload fetch_pc and leave drop_cnt unchanged.
REQ-029 inst_valid SHALL be low from the cycle after a redirect until the first new response is pushed.

Reset
REQ-030 While reset is low: mem_req = 0, mem_addr = RESET_PC, inst_valid = 0, inst_reg = 8'h00, inst_pc = 17'h00000, FIFO empty, outstanding = 0, drop_cnt = 0, state FETCH, fetch_pc = RESET_PC.
REQ-031 mem_req SHALL rise no earlier than the first clk edge after reset deasserts.
REQ-032 Reset asserted mid-operation SHALL abandon in-flight requests, and the memory model SHALL be reset at the same time.

Structure
REQ-033 A shared package SHALL hold PC_W=17, INST_W=8, the state enum (FETCH, STALL, DRAIN), and a struct {inst, pc} used as the FIFO entry.
REQ-034 The FIFO SHALL be one sub-module, inst_fifo, a parameterised synchronous FIFO with push, pop, clear, count, empty and full.

Verification
REQ-035 Reset, then memory with 1-cycle latency holding 8'h1D at address 0 and 8'h1F at address 1, inst_ready = 1 -> decode receives 8'h1D at pc 0 and then 8'h1F at pc 1, in order, with nothing lost or duplicated.
REQ-036 inst_ready = 0 for 20 cycles -> exactly FIFO_DEPTH words are fetched, the FSM is in STALL with mem_req low, and inst_reg holds 8'h1D stable.
REQ-037 mem_gnt held low for 5 cycles -> mem_addr stays constant and no pc is skipped.
REQ-038 Redirect to 17'h00040 with 2 requests outstanding at 3-cycle latency -> both stale responses are dropped, and the next inst_pc is 17'h00040 carrying the word at that address.
REQ-039 fetch_pc = 17'h1FFFF -> the next request address is 17'h00000.
REQ-040 reset pulsed low mid-stream -> all outputs match REQ-030 immediately, and fetching restarts at RESET_PC.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction prefetch unit.
// Holds the FSM state encoding and the FIFO entry layout.
package inst_fetch_pkg;

    localparam int PC_W   = 17;
    localparam int INST_W = 8;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        STALL = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } fifo_entry_t;

    // Program counter increment; wraps naturally at the top of the address space.
    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + {{(PC_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/inst_fetch_fifo.sv
// Synchronous prefetch FIFO of {inst, pc} entries with a clear that
// discards everything, used to flush the prefetch window on a redirect.
module inst_fifo
    import inst_fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  fifo_entry_t      push_data,
    input  logic             pop,
    output fifo_entry_t      head,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    fifo_entry_t      mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Status flags and guarded push/pop qualifiers.
    always_comb begin
        empty     = (count_r == '0);
        full      = (count_r == CNT_W'(DEPTH));
        do_push_s = push && !full;
        do_pop_s  = pop && !empty;
        count     = count_r;
        head      = mem_r[rd_ptr_r];
    end

    // Storage, pointers and occupancy; clear overrides push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (clear) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ptr_next(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= ptr_next(rd_ptr_r);
            end
            count_r <= count_r + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction prefetch unit: issues in-order program-memory reads under a
// credit limit, buffers responses, and flushes stale data on redirect.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int              FIFO_DEPTH = 4,
    parameter int              MAX_OUTST  = 2,
    parameter logic [PC_W-1:0] RESET_PC   = 17'h00000
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic [PC_W-1:0]   mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [INST_W-1:0] mem_rdata,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_reg,
    output logic [PC_W-1:0]   inst_pc
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OUT_W = $clog2(MAX_OUTST + 1);

    fetch_state_t     state_r;
    fetch_state_t     state_s;
    logic [PC_W-1:0]  fetch_pc_r;
    logic [PC_W-1:0]  fetch_pc_s;
    logic [PC_W-1:0]  resp_pc_r;
    logic [PC_W-1:0]  resp_pc_s;
    logic [OUT_W-1:0] outst_r;
    logic [OUT_W-1:0] outst_s;
    logic [OUT_W-1:0] drop_cnt_r;
    logic [OUT_W-1:0] drop_cnt_s;
    logic             run_r;
    logic             grant_s;
    logic             resp_s;
    logic             push_s;
    logic             pop_s;
    logic [CNT_W-1:0] fifo_count_s;
    logic [CNT_W-1:0] count_next_s;
    logic             fifo_empty_s;
    logic             fifo_full_s;
    logic [31:0]      used_next_s;
    logic             credit_full_s;
    fifo_entry_t      push_data_s;
    fifo_entry_t      head_s;

    inst_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .clear     (redirect),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .head      (head_s),
        .count     (fifo_count_s),
        .empty     (fifo_empty_s),
        .full      (fifo_full_s)
    );

    // run_r holds requests off until the first edge after reset release.
    assign mem_req    = run_r && (state_r == FETCH);
    assign mem_addr   = fetch_pc_r;
    assign inst_valid = !fifo_empty_s;
    assign inst_reg   = head_s.inst;
    assign inst_pc    = head_s.pc;

    // Handshakes, credit accounting and next-state selection.
    always_comb begin
        grant_s           = mem_req && mem_gnt;
        resp_s            = mem_rvalid && (outst_r != '0);
        pop_s             = inst_valid && inst_ready;
        push_s            = resp_s && (state_r != DRAIN) && !redirect && !fifo_full_s;
        push_data_s.inst  = mem_rdata;
        push_data_s.pc    = resp_pc_r;
        count_next_s      = redirect ? '0 : (fifo_count_s + CNT_W'(push_s) - CNT_W'(pop_s));
        outst_s           = outst_r + OUT_W'(grant_s) - OUT_W'(resp_s);
        used_next_s       = 32'(count_next_s) + 32'(outst_s);
        credit_full_s     = (used_next_s >= 32'(FIFO_DEPTH)) || (32'(outst_s) >= 32'(MAX_OUTST));
        state_s           = state_r;
        drop_cnt_s        = drop_cnt_r;

        if (grant_s) begin
            fetch_pc_s = pc_inc(fetch_pc_r);
        end else begin
            fetch_pc_s = fetch_pc_r;
        end
        if (push_s) begin
            resp_pc_s = pc_inc(resp_pc_r);
        end else begin
            resp_pc_s = resp_pc_r;
        end
        if ((state_r == DRAIN) && resp_s && (drop_cnt_r != '0)) begin
            drop_cnt_s = drop_cnt_r - OUT_W'(1);
        end else begin
            drop_cnt_s = drop_cnt_r;
        end

        if (redirect) begin
            fetch_pc_s = redirect_pc;
            resp_pc_s  = redirect_pc;
            // A redirect mid-drain keeps the existing drop count.
            if (state_r == DRAIN) begin
                state_s = (drop_cnt_s == '0) ? FETCH : DRAIN;
            end else begin
                drop_cnt_s = outst_s;
                state_s    = (outst_s == '0) ? FETCH : DRAIN;
            end
        end else begin
            case (state_r)
                FETCH:   state_s = credit_full_s ? STALL : FETCH;
                STALL:   state_s = credit_full_s ? STALL : FETCH;
                DRAIN:   state_s = (drop_cnt_s == '0) ? FETCH : DRAIN;
                default: state_s = FETCH;
            endcase
        end
    end

    // State, program counters and in-flight bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= FETCH;
            fetch_pc_r <= RESET_PC;
            resp_pc_r  <= RESET_PC;
            outst_r    <= '0;
            drop_cnt_r <= '0;
            run_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            fetch_pc_r <= fetch_pc_s;
            resp_pc_r  <= resp_pc_s;
            outst_r    <= outst_s;
            drop_cnt_r <= drop_cnt_s;
            run_r      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with an in-order memory model of
// configurable latency and a decode-side sequence monitor.
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_req;
    logic [16:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [7:0]  mem_rdata = 8'h00;
    logic        redirect = 1'b0;
    logic [16:0] redirect_pc = 17'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [7:0]  inst_reg;
    logic [16:0] inst_pc;

    int          total = 0;
    int          bad = 0;
    int          lat = 1;
    logic        gnt_en = 1'b0;
    int          cyc = 0;
    int          gnt_count = 0;
    logic [16:0] q_addr[$];
    int          q_due[$];
    logic [16:0] acc_pc[$];
    logic [7:0]  acc_inst[$];
    logic [16:0] exp_next = 17'h0;

    inst_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst_reg    (inst_reg),
        .inst_pc     (inst_pc)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mem_word(input logic [16:0] a);
        if (a == 17'h0) return 8'h1D;
        else if (a == 17'h1) return 8'h1F;
        else return a[7:0] ^ 8'h5A;
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_mem_req"},    32'(mem_req),    32'(0));
        check_val({tag, "_mem_addr"},   32'(mem_addr),   32'(0));
        check_val({tag, "_inst_valid"}, 32'(inst_valid), 32'(0));
        check_val({tag, "_inst_reg"},   32'(inst_reg),   32'(0));
        check_val({tag, "_inst_pc"},    32'(inst_pc),    32'(0));
    endtask

    task automatic apply_reset(input int l, input logic rdy);
        @(negedge clk);
        reset = 1'b0; lat = l; inst_ready = rdy; gnt_en = 1'b1; redirect = 1'b0;
        exp_next = 17'h0; acc_pc.delete(); acc_inst.delete(); gnt_count = 0;
        #2;
        check_reset_outputs("rst");
        step(2);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Memory model: grants and responses decided mid-cycle, in request order.
    always begin
        @(negedge clk);
        #1;
        cyc++;
        if (!reset) begin
            q_addr.delete(); q_due.delete();
            mem_rvalid = 1'b0; mem_gnt = 1'b0; mem_rdata = 8'h00;
        end else begin
            mem_rvalid = 1'b0; mem_rdata = 8'h00;
            if (q_due.size() > 0 && q_due[0] <= cyc) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_word(q_addr[0]);
                void'(q_addr.pop_front());
                void'(q_due.pop_front());
            end
            mem_gnt = gnt_en;
            if (mem_req && gnt_en) begin
                q_addr.push_back(mem_addr);
                q_due.push_back(cyc + lat);
                gnt_count++;
            end
        end
    end

    // Decode-side monitor: accepted words must follow the expected pc stream.
    always begin
        @(negedge clk);
        #1;
        if (reset && inst_valid && inst_ready) begin
            check_val("seq_pc",   32'(inst_pc),  32'(exp_next));
            check_val("seq_inst", 32'(inst_reg), 32'(mem_word(exp_next)));
            acc_pc.push_back(inst_pc);
            acc_inst.push_back(inst_reg);
            exp_next = exp_next + 17'd1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [16:0] held;
        logic        stable;
        logic        found;
        int          n_before;

        // Reset state, then 1-cycle latency stream with decode always ready.
        apply_reset(1, 1'b1);
        #2;
        check_val("req_before_edge", 32'(mem_req), 32'(0));
        @(negedge clk); #2;
        check_val("req_after_edge", 32'(mem_req), 32'(1));
        check_val("first_addr", 32'(mem_addr), 32'(0));
        @(negedge clk); #2;
        check_val("valid_latency_early", 32'(inst_valid), 32'(0));
        @(negedge clk); #2;
        check_val("valid_latency", 32'(inst_valid), 32'(1));
        check_val("first_inst", 32'(inst_reg), 32'(8'h1D));
        check_val("first_pc", 32'(inst_pc), 32'(0));
        step(4); #2;
        check_val("acc_ge2", 32'(acc_pc.size() >= 2), 32'(1));
        check_val("acc0_pc",   acc_pc.size() > 0 ? 32'(acc_pc[0]) : 32'hFFFF_FFFF, 32'(0));
        check_val("acc0_inst", acc_pc.size() > 0 ? 32'(acc_inst[0]) : 32'hFFFF_FFFF, 32'(8'h1D));
        check_val("acc1_pc",   acc_pc.size() > 1 ? 32'(acc_pc[1]) : 32'hFFFF_FFFF, 32'(1));
        check_val("acc1_inst", acc_pc.size() > 1 ? 32'(acc_inst[1]) : 32'hFFFF_FFFF, 32'(8'h1F));

        // Grant withheld for 5 cycles: address must hold, stream must not skip.
        @(negedge clk);
        gnt_en = 1'b0;
        @(negedge clk); #2;
        held = mem_addr; stable = 1'b1;
        repeat (5) begin
            @(negedge clk); #2;
            if (mem_addr !== held || mem_req !== 1'b1) stable = 1'b0;
        end
        check_val("gnt_hold_stable", 32'(stable), 32'(1));
        n_before = acc_pc.size();
        @(negedge clk);
        gnt_en = 1'b1;
        step(8); #2;
        check_val("gnt_resume", 32'(acc_pc.size() > n_before), 32'(1));

        // Decode stalled: window fills to FIFO_DEPTH and requests stop.
        apply_reset(1, 1'b0);
        stable = 1'b1;
        repeat (20) begin
            @(negedge clk); #2;
            if (inst_valid && inst_reg !== 8'h1D) stable = 1'b0;
        end
        check_val("stall_grants", 32'(gnt_count), 32'(4));
        check_val("stall_state", 32'(dut.state_r), 32'(STALL));
        check_val("stall_mem_req", 32'(mem_req), 32'(0));
        check_val("stall_valid", 32'(inst_valid), 32'(1));
        check_val("stall_inst", 32'(inst_reg), 32'(8'h1D));
        check_val("stall_stable", 32'(stable), 32'(1));
        @(negedge clk);
        inst_ready = 1'b1;
        step(12); #2;
        check_val("stall_release", 32'(acc_pc.size() >= 8), 32'(1));

        // Redirect with two reads in flight at 3-cycle latency.
        apply_reset(3, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk); #2;
            if (q_addr.size() == 2) found = 1'b1;
        end
        check_val("redir_two_outst", 32'(found), 32'(1));
        redirect = 1'b1; redirect_pc = 17'h00040; exp_next = 17'h00040;
        @(negedge clk);
        redirect = 1'b0;
        #2;
        check_val("redir_state", 32'(dut.state_r), 32'(DRAIN));
        check_val("redir_drop_cnt", 32'(dut.drop_cnt_r), 32'(2));
        check_val("redir_mem_req", 32'(mem_req), 32'(0));
        check_val("redir_valid_low", 32'(inst_valid), 32'(0));
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk); #2;
            if (inst_valid) found = 1'b1;
        end
        check_val("redir_valid_seen", 32'(found), 32'(1));
        check_val("redir_pc", 32'(inst_pc), 32'(17'h00040));
        check_val("redir_inst", 32'(inst_reg), 32'(8'h1A));

        // Address wrap from the top of program memory.
        step(3);
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 17'h1FFFF;
        #2;
        exp_next = 17'h1FFFF;
        @(negedge clk);
        redirect = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            #2;
            if (mem_req && mem_addr == 17'h1FFFF) found = 1'b1;
            else @(negedge clk);
        end
        check_val("wrap_top_req", 32'(found), 32'(1));
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk); #2;
            if (mem_req) found = 1'b1;
        end
        check_val("wrap_next_req", 32'(found), 32'(1));
        check_val("wrap_next_addr", 32'(mem_addr), 32'(0));
        step(15);

        // Reset pulsed mid-stream: outputs clear at once, fetch restarts at 0.
        @(negedge clk);
        reset = 1'b0; exp_next = 17'h0; acc_pc.delete(); acc_inst.delete();
        #2;
        check_reset_outputs("midrst");
        step(2);
        @(negedge clk);
        reset = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk); #2;
            if (mem_req) found = 1'b1;
        end
        check_val("midrst_restart", 32'(found), 32'(1));
        check_val("midrst_addr", 32'(mem_addr), 32'(0));
        step(12); #2;
        check_val("midrst_acc0", acc_pc.size() > 0 ? 32'(acc_pc[0]) : 32'hFFFF_FFFF, 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
